// File: rtl/seq_mon_pkg.sv
// Shared definitions for seq_hit_monitor: FSM state encodings and the
// ceil-log2 helper used to size the in-window bit counter.
package seq_mon_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Bits needed to index 0..value-1; a window of length 2 still needs one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/seq_mon_out_reg.sv
// Valid/ready holding register for completed window results. A result that
// arrives while the register is full and not draining is dropped and sets the
// sticky overrun flag. The alarm bit exists only when SEQ_MON_ALARM_EN is defined.
module seq_mon_out_reg #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             load_sat,
`ifdef SEQ_MON_ALARM_EN
  input  logic             load_alarm,
`endif
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat,
  output logic             out_valid,
  output logic             overrun
`ifdef SEQ_MON_ALARM_EN
  ,
  output logic             alarm
`endif
);

  logic take;
  logic accept;

  assign take   = out_valid && out_ready;
  // A draining slot may be refilled on the same edge; the reload wins.
  assign accept = !out_valid || take;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef SEQ_MON_ALARM_EN
      alarm     <= 1'b0;
`endif
    end else begin
      if (load && accept) begin
        out_cnt   <= load_cnt;
        out_sat   <= load_sat;
        out_valid <= 1'b1;
`ifdef SEQ_MON_ALARM_EN
        alarm     <= load_alarm;
`endif
      end else if (take) begin
        out_valid <= 1'b0;
`ifdef SEQ_MON_ALARM_EN
        alarm     <= 1'b0;
`endif
      end

      if (load && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_hit_monitor.sv
// Windowed hit counter downstream of the Mealy sequence detector: counts k over
// WIN_LEN-bit windows and hands each count to seq_mon_out_reg. Optional alarm: SEQ_MON_ALARM_EN.
module seq_hit_monitor
  import seq_mon_pkg::*;
#(
  parameter int WIN_LEN = 256,
  parameter int CNT_W   = 9,
  parameter int THRESH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             k,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
`ifdef SEQ_MON_ALARM_EN
  ,
  output logic             alarm
`endif
);

  localparam int               BIT_W    = clog2(WIN_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic             sat;

  logic [CNT_W-1:0] hit_next;
  logic             sat_next;
  logic             win_end;

  // A only marks the bit slot; its value carries no information here.
  logic unused_a;
  assign unused_a = A;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hit_next = hit_cnt;
    sat_next = sat;
    if (k) begin
      if (hit_cnt == CNT_MAX) sat_next = 1'b1;
      else                    hit_next = hit_cnt + CNT_W'(1);
    end
  end

  // Dropping en on the last bit aborts the window rather than completing it.
  assign win_end = (state == COUNT) && en && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      hit_cnt <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          hit_cnt <= '0;
          sat     <= 1'b0;
          if (en) state <= COUNT;
        end
        COUNT: begin
          if (!en || win_end) begin
            bit_cnt <= '0;
            hit_cnt <= '0;
            sat     <= 1'b0;
            if (!en) state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            hit_cnt <= hit_next;
            sat     <= sat_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_MON_ALARM_EN
  logic load_alarm;
  assign load_alarm = (int'(hit_next) >= THRESH);
`endif

  seq_mon_out_reg #(
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (win_end),
    .load_cnt   (hit_next),
    .load_sat   (sat_next),
`ifdef SEQ_MON_ALARM_EN
    .load_alarm (load_alarm),
`endif
    .out_ready  (out_ready),
    .out_cnt    (out_cnt),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .overrun    (overrun)
`ifdef SEQ_MON_ALARM_EN
    ,
    .alarm      (alarm)
`endif
  );

endmodule
